// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg
// Shared front-end types for the branch history table.
//   bp_fe_bht_state_e : BHT sequencing state. The table is swept once after
//                       reset (e_bht_init) before it serves traffic
//                       (e_bht_ready).
package bp_fe_pkg;

  typedef enum logic {
    e_bht_init  = 1'b0,
    e_bht_ready = 1'b1
  } bp_fe_bht_state_e;

endpackage

// File: rtl/bp_fe_sat_ctr.sv
// bp_fe_sat_ctr
// Combinational saturating up/down counter step.
// Ports:
//   ctr_i   : current counter value
//   taken_i : 1 = count up (branch taken), 0 = count down
//   ctr_o   : next counter value, clamped to [0, 2**ctr_width_p-1]
module bp_fe_sat_ctr #(
  parameter int ctr_width_p = 2
) (
  input  logic [ctr_width_p-1:0] ctr_i,
  input  logic                   taken_i,
  output logic [ctr_width_p-1:0] ctr_o
);

  // Hold at the rails instead of wrapping. Wrapping would turn a strongly
  // taken counter into a strongly not-taken one.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != '1) begin
        ctr_o = ctr_i + 1'b1;
      end
    end else begin
      if (ctr_i != '0) begin
        ctr_o = ctr_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_dff.sv
// bsg_dff
// Plain positive-edge register with no reset. It is used for datapath values
// whose validity is tracked by a separate, reset-controlled valid bit.
// Ports:
//   clk_i  : clock
//   data_i : value captured on every rising edge
//   data_o : registered value
module bsg_dff #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // Capture unconditionally. Consumers qualify the value with their own valid.
  always_ff @(posedge clk_i) begin
    data_o <= data_i;
  end

endmodule

// File: rtl/bsg_mem_1r1w.sv
// bsg_mem_1r1w
// One-write, one-read register-file memory. The write is synchronous and
// lands at the end of the cycle. The read is asynchronous, so a read address
// presented in a later cycle sees any write committed at an earlier edge.
// Ports:
//   clk_i    : clock
//   w_v_i    : write enable
//   w_addr_i : write address
//   w_data_i : write data
//   r_addr_i : read address
//   r_data_o : read data (combinational from r_addr_i)
module bsg_mem_1r1w #(
  parameter int width_p = 2,
  parameter int els_p   = 512,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  // No reset on the array. The owner is responsible for sweeping it to a
  // known value before any read result is used.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_fe_bht_gshare.sv
// bp_fe_bht_gshare
// Gshare branch history table for the FE pc-gen stage. Saturating counters
// are indexed by PC index bits XOR the global history. A prediction appears
// one cycle after its lookup. Resolved-branch updates come from the back end.
// After reset the table is swept to "weakly not taken", one entry per cycle.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   ready_o          : table initialised; lookups and updates are honoured
//   r_v_i, r_idx_i   : lookup request and PC index bits
//   predict_v_o      : prediction valid (lookup accepted last cycle)
//   predict_o        : predicted taken
//   predict_ghist_o  : history used to hash that lookup
//   w_v_i            : resolved-branch update
//   w_idx_i          : PC index bits of the resolved branch
//   w_ghist_i        : history returned with the branch
//   w_taken_i        : actual direction
//   w_mispredict_i   : restore speculative history from w_ghist_i/w_taken_i
//   ghist_o          : current speculative global history
module bp_fe_bht_gshare
  import bp_fe_pkg::*;
#(
  parameter int bht_idx_width_p = 9,
  parameter int ghist_width_p   = 8,
  parameter int ctr_width_p     = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic                       ready_o,

  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  output logic [ghist_width_p-1:0]   predict_ghist_o,

  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic [ghist_width_p-1:0]   w_ghist_i,
  input  logic                       w_taken_i,
  input  logic                       w_mispredict_i,
  output logic [ghist_width_p-1:0]   ghist_o
);

  localparam int els_lp = 1 << bht_idx_width_p;
  localparam logic [ctr_width_p-1:0] ctr_init_lp = {1'b0, {(ctr_width_p-1){1'b1}}};

  // Shift one outcome into the young end of a history value. The extra bit
  // of the temporary lets this also work for a one-bit history.
  function automatic logic [ghist_width_p-1:0] hist_shift(
    input logic [ghist_width_p-1:0] hist,
    input logic                     bit_in
  );
    logic [ghist_width_p:0] tmp;
    tmp = {hist, bit_in};
    return tmp[ghist_width_p-1:0];
  endfunction

  bp_fe_bht_state_e           state_r, state_n;
  logic [bht_idx_width_p-1:0] init_ptr_r, init_ptr_n;
  logic [ghist_width_p-1:0]   ghist_r, ghist_n;
  logic                       predict_v_r;

  logic                       ready;
  logic                       r_fire, w_fire, restore;
  logic [bht_idx_width_p-1:0] r_hash, w_hash, r_hash_r;
  logic [ghist_width_p-1:0]   r_ghist_r;

  logic                       mem_w_v;
  logic [bht_idx_width_p-1:0] mem_w_addr;
  logic [ctr_width_p-1:0]     mem_w_data;
  logic [ctr_width_p-1:0]     lookup_ctr, update_ctr, update_ctr_next;

  assign ready   = (state_r == e_bht_ready);
  assign ready_o = ready;

  // Traffic is dropped until the sweep completes. Otherwise a counter could
  // be written before it is initialised, or a lookup could read garbage.
  assign r_fire  = ready & r_v_i;
  assign w_fire  = ready & w_v_i;
  assign restore = w_fire & w_mispredict_i;

  // The history is narrower than or equal to the index, so it is
  // zero-extended into the low index bits.
  assign r_hash = r_idx_i ^ bht_idx_width_p'(ghist_r);
  assign w_hash = w_idx_i ^ bht_idx_width_p'(w_ghist_i);

  // State and sweep pointer register. Reset restarts the sweep from entry 0,
  // so entries that were only partly written are overwritten again.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_bht_init;
      init_ptr_r <= '0;
    end else begin
      state_r    <= state_n;
      init_ptr_r <= init_ptr_n;
    end
  end

  // Sweep one entry per cycle. The last entry is written in the cycle that
  // leaves e_bht_init. e_bht_ready is held until the next reset.
  always_comb begin
    state_n    = state_r;
    init_ptr_n = init_ptr_r;
    unique case (state_r)
      e_bht_init: begin
        init_ptr_n = init_ptr_r + 1'b1;
        if (init_ptr_r == bht_idx_width_p'(els_lp - 1)) begin
          state_n = e_bht_ready;
        end
      end
      e_bht_ready: begin
        state_n = e_bht_ready;
      end
      default: begin
        state_n = e_bht_init;
      end
    endcase
  end

  // Speculative history. A misprediction restore rebuilds the history from
  // the branch's own snapshot plus its real outcome. It overrides the
  // speculative shift of any prediction that is valid in the same cycle,
  // because that prediction came from the wrong path.
  always_comb begin
    ghist_n = ghist_r;
    if (ready) begin
      if (restore) begin
        ghist_n = hist_shift(w_ghist_i, w_taken_i);
      end else if (predict_v_r) begin
        ghist_n = hist_shift(ghist_r, predict_o);
      end
    end
  end

  // History and prediction-valid registers. Both reset so that all outputs
  // clear as soon as reset asserts.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ghist_r     <= '0;
      predict_v_r <= 1'b0;
    end else begin
      ghist_r     <= ghist_n;
      predict_v_r <= r_fire;
    end
  end

  assign ghist_o = ghist_r;

  // Read index and the history used to hash it. The prediction is formed
  // in the next cycle from this registered index.
  bsg_dff #(.width_p(bht_idx_width_p)) r_idx_reg (
    .clk_i  (clk_i),
    .data_i (r_hash),
    .data_o (r_hash_r)
  );

  bsg_dff #(.width_p(ghist_width_p)) r_ghist_reg (
    .clk_i  (clk_i),
    .data_i (ghist_r),
    .data_o (r_ghist_r)
  );

  // The single write port is shared between the sweep and branch updates.
  // It is never shared in the same cycle, because updates are blocked until
  // ready.
  always_comb begin
    mem_w_v    = 1'b0;
    mem_w_addr = init_ptr_r;
    mem_w_data = ctr_init_lp;
    if (!ready) begin
      mem_w_v = 1'b1;
    end else if (w_fire) begin
      mem_w_v    = 1'b1;
      mem_w_addr = w_hash;
      mem_w_data = update_ctr_next;
    end
  end

  // The counter array is stored twice, and both copies take every write.
  // One copy serves lookups and the other serves update read-modify-write,
  // so each copy has one read port. Because the read index is registered
  // and the read is asynchronous, an update in cycle N is visible to a
  // lookup issued in cycle N; that is the forwarding for matching hashed
  // indices. An update in N+1 commits only at the end of N+1, so the N+1
  // prediction shows the older value.
  bsg_mem_1r1w #(.width_p(ctr_width_p), .els_p(els_lp)) lookup_bank (
    .clk_i    (clk_i),
    .w_v_i    (mem_w_v),
    .w_addr_i (mem_w_addr),
    .w_data_i (mem_w_data),
    .r_addr_i (r_hash_r),
    .r_data_o (lookup_ctr)
  );

  bsg_mem_1r1w #(.width_p(ctr_width_p), .els_p(els_lp)) update_bank (
    .clk_i    (clk_i),
    .w_v_i    (mem_w_v),
    .w_addr_i (mem_w_addr),
    .w_data_i (mem_w_data),
    .r_addr_i (w_hash),
    .r_data_o (update_ctr)
  );

  bp_fe_sat_ctr #(.ctr_width_p(ctr_width_p)) update_step (
    .ctr_i   (update_ctr),
    .taken_i (w_taken_i),
    .ctr_o   (update_ctr_next)
  );

  // Outputs are gated by the valid bit. The registered index and history
  // have no reset and may hold stale data when no prediction is valid.
  assign predict_v_o     = predict_v_r;
  assign predict_o       = predict_v_r & lookup_ctr[ctr_width_p-1];
  assign predict_ghist_o = predict_v_r ? r_ghist_r : '0;

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// tb_bp_fe_bht_gshare
// Directed bench for the gshare BHT. Instance a uses the default geometry
// (512 entries, 8-bit history, 2-bit counters). Instance b uses 16 entries,
// 4-bit history and 3-bit counters to exercise the wider counter. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_bp_fe_bht_gshare;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic reset_n_i;

  logic       r_v_a, w_v_a, w_taken_a, w_mis_a;
  logic [8:0] r_idx_a, w_idx_a;
  logic [7:0] w_ghist_a;
  logic       ready_a, pv_a, p_a;
  logic [7:0] pgh_a, gh_a;

  logic       r_v_b, w_v_b, w_taken_b, w_mis_b;
  logic [3:0] r_idx_b, w_idx_b;
  logic [3:0] w_ghist_b;
  logic       ready_b, pv_b, p_b;
  logic [3:0] pgh_b, gh_b;

  bp_fe_bht_gshare dut_a (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .ready_o         (ready_a),
    .r_v_i           (r_v_a),
    .r_idx_i         (r_idx_a),
    .predict_v_o     (pv_a),
    .predict_o       (p_a),
    .predict_ghist_o (pgh_a),
    .w_v_i           (w_v_a),
    .w_idx_i         (w_idx_a),
    .w_ghist_i       (w_ghist_a),
    .w_taken_i       (w_taken_a),
    .w_mispredict_i  (w_mis_a),
    .ghist_o         (gh_a)
  );

  bp_fe_bht_gshare #(.bht_idx_width_p(4), .ghist_width_p(4), .ctr_width_p(3)) dut_b (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .ready_o         (ready_b),
    .r_v_i           (r_v_b),
    .r_idx_i         (r_idx_b),
    .predict_v_o     (pv_b),
    .predict_o       (p_b),
    .predict_ghist_o (pgh_b),
    .w_v_i           (w_v_b),
    .w_idx_i         (w_idx_b),
    .w_ghist_i       (w_ghist_b),
    .w_taken_i       (w_taken_b),
    .w_mispredict_i  (w_mis_b),
    .ghist_o         (gh_b)
  );

  typedef struct {
    bit sel;
    int rep;
    bit rv;
    int ridx;
    bit wv;
    int widx;
    int wgh;
    bit wtk;
    bit wmis;
    bit epv;
    bit ep;
    int epgh;
    int egh;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_a, cnt_b;

  function automatic vec_t mk(input bit sel, input int rep, input bit rv, input int ridx,
                              input bit wv, input int widx, input int wgh, input bit wtk,
                              input bit wmis, input bit epv, input bit ep, input int epgh,
                              input int egh);
    vec_t v;
    v.sel = sel; v.rep = rep; v.rv = rv; v.ridx = ridx;
    v.wv = wv; v.widx = widx; v.wgh = wgh; v.wtk = wtk; v.wmis = wmis;
    v.epv = epv; v.ep = ep; v.epgh = epgh; v.egh = egh;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idleAll();
    r_v_a = 0; r_idx_a = '0; w_v_a = 0; w_idx_a = '0; w_ghist_a = '0; w_taken_a = 0; w_mis_a = 0;
    r_v_b = 0; r_idx_b = '0; w_v_b = 0; w_idx_b = '0; w_ghist_b = '0; w_taken_b = 0; w_mis_b = 0;
  endtask

  // Called at a falling edge. Drives one vector for one cycle, checks the
  // prediction one cycle later, then checks the history after the shift.
  task automatic applyStimulus(input int id, input vec_t v);
    for (int k = 0; k < v.rep; k++) begin
      if (!v.sel) begin
        r_v_a = v.rv; r_idx_a = v.ridx[8:0]; w_v_a = v.wv; w_idx_a = v.widx[8:0];
        w_ghist_a = v.wgh[7:0]; w_taken_a = v.wtk; w_mis_a = v.wmis;
      end else begin
        r_v_b = v.rv; r_idx_b = v.ridx[3:0]; w_v_b = v.wv; w_idx_b = v.widx[3:0];
        w_ghist_b = v.wgh[3:0]; w_taken_b = v.wtk; w_mis_b = v.wmis;
      end
      @(negedge clk_i);
      idleAll();
      if (!v.sel) begin
        checkOutput($sformatf("vec%0d.%0d predict_v", id, k), int'(pv_a), int'(v.epv));
        checkOutput($sformatf("vec%0d.%0d predict", id, k), int'(p_a), int'(v.ep));
        checkOutput($sformatf("vec%0d.%0d predict_ghist", id, k), int'(pgh_a), v.epgh);
      end else begin
        checkOutput($sformatf("vec%0d.%0d predict_v", id, k), int'(pv_b), int'(v.epv));
        checkOutput($sformatf("vec%0d.%0d predict", id, k), int'(p_b), int'(v.ep));
        checkOutput($sformatf("vec%0d.%0d predict_ghist", id, k), int'(pgh_b), v.epgh);
      end
      @(negedge clk_i);
      if (!v.sel) checkOutput($sformatf("vec%0d.%0d ghist", id, k), int'(gh_a), v.egh);
      else        checkOutput($sformatf("vec%0d.%0d ghist", id, k), int'(gh_b), v.egh);
    end
  endtask

  // Called at the falling edge right after reset release. Counts rising
  // edges until each instance reports ready. Optionally drives lookups,
  // updates and a restore into instance a mid-sweep; all must be ignored.
  task automatic countInit(input bit junk, output int ca, output int cb);
    ca = 0; cb = 0;
    for (int c = 1; c <= 2000 && ca == 0; c++) begin
      @(negedge clk_i);
      if (ready_b && cb == 0) cb = c;
      if (ready_a) ca = c;
      if (junk && c == 202) begin
        checkOutput("init_ignore predict_v", int'(pv_a), 0);
        checkOutput("init_ignore ghist", int'(gh_a), 0);
      end
      if (junk && c >= 200 && c <= 201) begin
        r_v_a = 1; r_idx_a = 9'd5; w_v_a = 1; w_idx_a = 9'd5; w_ghist_a = 8'h00;
        w_taken_a = 1; w_mis_a = 0;
        if (c == 201) begin
          w_ghist_a = 8'hFF; w_mis_a = 1;
        end
      end else begin
        idleAll();
      end
    end
  endtask

  initial begin
    idleAll();
    reset_n_i = 1'b0;
    #23;
    checkOutput("reset ready", int'(ready_a), 0);
    checkOutput("reset predict_v", int'(pv_a), 0);
    checkOutput("reset predict", int'(p_a), 0);
    checkOutput("reset predict_ghist", int'(pgh_a), 0);
    checkOutput("reset ghist", int'(gh_a), 0);

    @(negedge clk_i);
    reset_n_i = 1'b1;
    countInit(1'b0, cnt_a, cnt_b);
    checkOutput("init_cycles_a", cnt_a, 512);
    checkOutput("init_cycles_b", cnt_b, 16);

    // Instance a: 2-bit counters on entry 5. A restore with an all-zero
    // snapshot brings the history back to 0 after each taken prediction.
    vecs.push_back(mk(0,1, 1,0,   0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,1, 1,255, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,1, 1,511, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,3, 0,0,   1,5,0,1,0, 0,0,0,0));
    vecs.push_back(mk(0,1, 1,5,   0,0,0,0,0, 1,1,0,1));
    vecs.push_back(mk(0,1, 0,0,   1,500,0,0,1, 0,0,0,0));
    vecs.push_back(mk(0,1, 0,0,   1,5,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1, 1,5,   0,0,0,0,0, 1,1,0,1));
    vecs.push_back(mk(0,1, 0,0,   1,500,0,0,1, 0,0,0,0));
    vecs.push_back(mk(0,1, 0,0,   1,5,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1, 1,5,   0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,2, 0,0,   1,5,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,2, 0,0,   1,5,0,1,0, 0,0,0,0));
    vecs.push_back(mk(0,1, 1,5,   0,0,0,0,0, 1,1,0,1));
    vecs.push_back(mk(0,1, 0,0,   1,500,0,0,1, 0,0,0,0));
    vecs.push_back(mk(0,1, 0,0,   1,20,0,1,0, 0,0,0,0));
    vecs.push_back(mk(0,1, 0,0,   1,41,0,1,0, 0,0,0,0));
    // Instance b: 3-bit counters on entry 3, init 011.
    vecs.push_back(mk(1,1, 1,3,   0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(1,5, 0,0,   1,3,0,1,0, 0,0,0,0));
    vecs.push_back(mk(1,1, 1,3,   0,0,0,0,0, 1,1,0,1));
    vecs.push_back(mk(1,1, 0,0,   1,9,0,0,1, 0,0,0,0));
    vecs.push_back(mk(1,4, 0,0,   1,3,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,1, 1,3,   0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(1,4, 0,0,   1,3,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,4, 0,0,   1,3,0,1,0, 0,0,0,0));
    vecs.push_back(mk(1,1, 1,3,   0,0,0,0,0, 1,1,0,1));

    @(negedge clk_i);
    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Back-to-back predictions: taken (entry 20), not taken (30), then
    // taken (40 ^ history 1 = 41).
    r_v_a = 1; r_idx_a = 9'd20;
    @(negedge clk_i);
    checkOutput("b2b0 predict_v", int'(pv_a), 1);
    checkOutput("b2b0 predict", int'(p_a), 1);
    r_idx_a = 9'd30;
    @(negedge clk_i);
    checkOutput("b2b1 predict", int'(p_a), 0);
    checkOutput("b2b1 predict_ghist", int'(pgh_a), 0);
    checkOutput("b2b1 ghist", int'(gh_a), 1);
    r_idx_a = 9'd40;
    @(negedge clk_i);
    checkOutput("b2b2 predict", int'(p_a), 1);
    checkOutput("b2b2 predict_ghist", int'(pgh_a), 1);
    checkOutput("b2b2 ghist", int'(gh_a), 2);
    r_v_a = 0;
    @(negedge clk_i);
    checkOutput("b2b ghist_101", int'(gh_a), 5);

    // Restore in the same cycle as a taken prediction. The shift is dropped.
    r_v_a = 1; r_idx_a = 9'd17;
    @(negedge clk_i);
    checkOutput("restore predict", int'(p_a), 1);
    checkOutput("restore predict_ghist", int'(pgh_a), 5);
    r_v_a = 0; w_v_a = 1; w_mis_a = 1; w_idx_a = 9'h100; w_ghist_a = 8'h0F; w_taken_a = 0;
    @(negedge clk_i);
    idleAll();
    checkOutput("restore ghist", int'(gh_a), 8'h1E);

    // Same-cycle lookup and update on hashed entry 60: forwarded. An update
    // in the prediction cycle must not yet be visible.
    r_v_a = 1; r_idx_a = 9'h022; w_v_a = 1; w_idx_a = 9'd60; w_ghist_a = 8'h00; w_taken_a = 1;
    @(negedge clk_i);
    checkOutput("fwd predict_v", int'(pv_a), 1);
    checkOutput("fwd predict", int'(p_a), 1);
    checkOutput("fwd predict_ghist", int'(pgh_a), 8'h1E);
    r_v_a = 0; w_v_a = 1; w_idx_a = 9'd60; w_ghist_a = 8'h00; w_taken_a = 0;
    #1;
    checkOutput("preupdate predict", int'(p_a), 1);
    @(negedge clk_i);
    idleAll();
    checkOutput("fwd ghist", int'(gh_a), 8'h3D);
    r_v_a = 1; r_idx_a = 9'h001;
    @(negedge clk_i);
    r_v_a = 0;
    checkOutput("post_update predict", int'(p_a), 0);
    checkOutput("post_update predict_ghist", int'(pgh_a), 8'h3D);
    @(negedge clk_i);
    checkOutput("post_update ghist", int'(gh_a), 8'h7A);
    r_v_a = 1; r_idx_a = 9'h06E;
    @(negedge clk_i);
    r_v_a = 0;
    checkOutput("pre_reset predict", int'(p_a), 1);

    // Reset while a prediction is valid: outputs clear immediately.
    #2 reset_n_i = 1'b0;
    #1;
    checkOutput("midreset ready", int'(ready_a), 0);
    checkOutput("midreset predict_v", int'(pv_a), 0);
    checkOutput("midreset predict", int'(p_a), 0);
    checkOutput("midreset predict_ghist", int'(pgh_a), 0);
    checkOutput("midreset ghist", int'(gh_a), 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (100) @(negedge clk_i);
    checkOutput("ptr100 ready", int'(ready_a), 0);
    #2 reset_n_i = 1'b0;
    #1;
    checkOutput("ptr100 reset ready", int'(ready_a), 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    countInit(1'b1, cnt_a, cnt_b);
    checkOutput("reinit_cycles_a", cnt_a, 512);
    applyStimulus(100, mk(0,1, 1,5, 0,0,0,0,0, 1,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_gshare.md
# bp_fe_bht_gshare

Parametrised gshare branch history table for the front end: a table of N-bit saturating counters indexed by PC bits XOR a global history register. Returns a taken/not-taken prediction one cycle after a lookup and applies resolved-branch updates from the back end. After reset, a state machine initialises the table one entry per cycle, so the array needs no reset port. Speculative history is updated per prediction and restored on a misprediction. Sits in the FE pc-gen stage beside the BTB.

## Interface
- bht_idx_width_p, 9, log2 of table entries (els = 2**bht_idx_width_p)
- ghist_width_p, 8, global history length; 1 ≤ ghist_width_p ≤ bht_idx_width_p
- ctr_width_p, 2, saturating counter width; 2..4
- clk_i  in  1  clock, all state on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- ready_o  out  1  table initialised; lookups and updates accepted
- r_v_i  in  1  lookup request
- r_idx_i  in  bht_idx_width_p  PC index bits of the lookup
- predict_v_o  out  1  prediction valid (lookup accepted previous cycle)
- predict_o  out  1  predicted taken
- predict_ghist_o  out  ghist_width_p  history used by this lookup; carried with the branch and returned on update
- w_v_i  in  1  resolved-branch update
- w_idx_i  in  bht_idx_width_p  PC index bits of the resolved branch
- w_ghist_i  in  ghist_width_p  predict_ghist_o captured at lookup
- w_taken_i  in  1  actual direction
- w_mispredict_i  in  1  direction was mispredicted; restore history
- ghist_o  out  ghist_width_p  current speculative global history

## Operation
- Hash: idx = r_idx_i XOR zero-extend(ghist); updates use w_idx_i XOR zero-extend(w_ghist_i).
- Counter: predict taken iff MSB = 1. Update: taken → +1, saturating at 2**ctr_width_p−1; not-taken → −1, saturating at 0. Width is exactly ctr_width_p with no wrap. Init value = 2**(ctr_width_p−1)−1 (weakly not taken; 01 for width 2).
- FSM states: e_bht_init and e_bht_ready.
  - Reset enters e_bht_init with init pointer 0.
  - e_bht_init writes the init value to entry[ptr] and increments ptr each cycle. When ptr = els−1, moves to e_bht_ready (els cycles total).
  - e_bht_ready is terminal until the next reset.
- While not ready: r_v_i and w_v_i are ignored, with no table write and no history change. predict_v_o stays 0.
- Speculative history: when predict_v_o = 1, ghist ← {ghist[ghist_width_p−2:0], predict_o} at the clock edge.
- Restore: w_v_i & w_mispredict_i sets ghist ← {w_ghist_i[ghist_width_p−2:0], w_taken_i}. This takes priority over a same-cycle speculative shift. predict_o still drives that cycle but does not shift history.
- w_v_i without mispredict: counter update only, ghist unchanged.
- A lookup in cycle N+1 hashes with ghist not yet including the prediction produced in N+1. This is documented behaviour.
- Single write port; only one update per cycle.

## Timing
- Reset values: ready_o 0, predict_v_o 0, predict_o 0, predict_ghist_o 0, ghist_o 0.
- ready_o rises els cycles after reset_n_i deasserts.
- Lookup latency is 1 cycle. A lookup accepted in cycle N drives predict_v_o, predict_o and predict_ghist_o in N+1, combinational from the registered index.
- Update is written at the end of its cycle. If a lookup in cycle N and an update in cycle N hit the same hashed index, the N+1 prediction reflects the updated counter (write forwarding).
- Update and prediction hitting the same index in cycle N+1 (update not forwarded into a read issued in N): the prediction uses the pre-update value.
- Reset asserted mid-operation clears all outputs immediately. Initialisation restarts from entry 0 after deassertion. No partially initialised entry survives.

## Structure
- bp_fe_pkg gets the typedef enum bp_fe_bht_state_e {e_bht_init, e_bht_ready}.
- Sub-module bp_fe_sat_ctr: combinational saturating inc/dec of width ctr_width_p, with inputs ctr_i and taken_i and output ctr_o.
- The array is bsg_mem_1r1w with the read index held in a bsg_dff, plus the forwarding compare on hashed index.

## Test plan
- Reset, then count cycles → ready_o = 0 for exactly 512 cycles (defaults), then 1. Lookups on idx 0, 255 and 511 then give predict_o = 0 with predict_v_o = 1.
- Three taken updates to idx 5 with ghist 0 → counter 01→10→11→11. A lookup at idx 5 with ghist 0 → predict_o = 1, and the counter stays saturated.
- Four not-taken updates on a saturated entry → 11→10→01→00→00. Repeat with ctr_width_p = 3, init 011: saturate at 111 and 000.
- Back-to-back predictions taken, not-taken, taken from ghist 0 → ghist_o = 0b101. A same-cycle mispredict update with w_ghist_i = 0x0F and w_taken_i = 0 → ghist_o = 0x1E and the speculative shift is dropped.
- Same-cycle lookup and update to the same hashed index → prediction shows the post-update counter.
- Assert reset_n_i at init pointer 100 → outputs 0 immediately. After release, ready_o again takes a full 512 cycles. Lookups or updates during init are ignored.
